// File: rtl/mlp_layer_ctrl_if.sv
// Control/config inputs and beat outputs of the MLP layer sequencer.
// The master side issues layers; the slave side is the sequencer itself.
interface mlp_layer_ctrl_if;
    logic        run;
    logic        start;
    logic        stall;
    logic [11:0] num_inputs;
    logic [11:0] num_outputs;
    logic [11:0] in_base;
    logic [11:0] out_base;
    logic [15:0] w_base;

    logic [11:0] in_addr;
    logic [15:0] w_addr;
    logic        mac_valid;
    logic        mac_clear;
    logic [11:0] out_neuron_addr_0;
    logic        write_neuron_0;
    logic        done_0;
    logic        busy;

    modport master (
        output run, start, stall, num_inputs, num_outputs, in_base, out_base, w_base,
        input  in_addr, w_addr, mac_valid, mac_clear, out_neuron_addr_0,
               write_neuron_0, done_0, busy
    );

    modport slave (
        input  run, start, stall, num_inputs, num_outputs, in_base, out_base, w_base,
        output in_addr, w_addr, mac_valid, mac_clear, out_neuron_addr_0,
               write_neuron_0, done_0, busy
    );
endinterface

// File: rtl/mlp_layer_ctrl.sv
// MLP layer sequencer: walks num_outputs x num_inputs MAC beats with registered
// read addresses and strobes, then waits PIPE_DEPTH cycles for write-back to drain.
module mlp_layer_ctrl #(
    parameter int PIPE_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mlp_layer_ctrl_if.slave bus
);
    localparam int DW = $clog2(PIPE_DEPTH + 1) + 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_DEPTH);

    typedef enum logic [1:0] {IDLE, MAC, DRAIN} state_t;

    state_t        state;
    logic [11:0]   n_in, n_out, in_base_q, out_base_q;
    logic [11:0]   i_cnt, j_cnt;
    logic [15:0]   w_ptr;
    logic [DW-1:0] drain_cnt;

    logic          load, zero_req, issue, last_i, last_j;
    logic [11:0]   src_n_in, src_n_out, src_in_base, src_out_base, src_i, src_j;
    logic [15:0]   src_w;

    // The load edge already emits beat (0,0), so its beat is built from the
    // config inputs; every later beat comes from the latched config and counters.
    always_comb begin
        load     = (state == IDLE) && bus.run && bus.start &&
                   (bus.num_inputs != 12'd0) && (bus.num_outputs != 12'd0);
        zero_req = (state == IDLE) && bus.run && bus.start && !load;
        issue    = load || ((state == MAC) && bus.run && !bus.stall);
        if (load) begin
            src_n_in     = bus.num_inputs;
            src_n_out    = bus.num_outputs;
            src_in_base  = bus.in_base;
            src_out_base = bus.out_base;
            src_i        = 12'd0;
            src_j        = 12'd0;
            src_w        = bus.w_base;
        end else begin
            src_n_in     = n_in;
            src_n_out    = n_out;
            src_in_base  = in_base_q;
            src_out_base = out_base_q;
            src_i        = i_cnt;
            src_j        = j_cnt;
            src_w        = w_ptr;
        end
        last_i = (src_i == src_n_in - 12'd1);
        last_j = (src_j == src_n_out - 12'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= IDLE;
            n_in                  <= '0;
            n_out                 <= '0;
            in_base_q             <= '0;
            out_base_q            <= '0;
            i_cnt                 <= '0;
            j_cnt                 <= '0;
            w_ptr                 <= '0;
            drain_cnt             <= '0;
            bus.in_addr           <= '0;
            bus.w_addr            <= '0;
            bus.out_neuron_addr_0 <= '0;
            bus.mac_valid         <= 1'b0;
            bus.mac_clear         <= 1'b0;
            bus.write_neuron_0    <= 1'b0;
            bus.done_0            <= 1'b0;
            bus.busy              <= 1'b0;
        end else if (!bus.run) begin
            state              <= IDLE;
            i_cnt              <= '0;
            j_cnt              <= '0;
            drain_cnt          <= '0;
            bus.mac_valid      <= 1'b0;
            bus.mac_clear      <= 1'b0;
            bus.write_neuron_0 <= 1'b0;
            bus.done_0         <= 1'b0;
            bus.busy           <= 1'b0;
        end else begin
            bus.mac_valid      <= 1'b0;
            bus.mac_clear      <= 1'b0;
            bus.write_neuron_0 <= 1'b0;
            bus.done_0         <= 1'b0;

            case (state)
                IDLE: begin
                    bus.busy <= 1'b0;
                    if (zero_req) bus.done_0 <= 1'b1;
                end
                MAC: begin
                    bus.busy <= 1'b1;
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (issue) begin
                bus.mac_valid         <= 1'b1;
                bus.busy              <= 1'b1;
                bus.in_addr           <= src_in_base + src_i;
                bus.w_addr            <= src_w;
                bus.out_neuron_addr_0 <= src_out_base + src_j;
                bus.mac_clear         <= (src_i == 12'd0);
                bus.write_neuron_0    <= last_i;
                bus.done_0            <= last_i && last_j;
                w_ptr                 <= src_w + 16'd1;
                if (load) begin
                    n_in       <= bus.num_inputs;
                    n_out      <= bus.num_outputs;
                    in_base_q  <= bus.in_base;
                    out_base_q <= bus.out_base;
                end
                if (last_i) begin
                    i_cnt <= '0;
                    if (last_j) begin
                        j_cnt     <= '0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        j_cnt <= src_j + 12'd1;
                        state <= MAC;
                    end
                end else begin
                    i_cnt <= src_i + 12'd1;
                    state <= MAC;
                end
            end
        end
    end
endmodule

// File: tb/tb_mlp_layer_ctrl.sv
// Scoreboard bench for mlp_layer_ctrl: a reference model enumerates each layer's
// beats into a queue and a negedge monitor pops and compares every issued beat.
module tb_mlp_layer_ctrl;
    localparam int PD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mlp_layer_ctrl_if bus();
    mlp_layer_ctrl #(.PIPE_DEPTH(PD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [11:0] in_addr;
        logic [15:0] w_addr;
        logic [11:0] tag;
        logic        clr;
        logic        wr;
        logic        dn;
        int          cyc;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    allow_lone_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: beat k of a layer is (j, i) in row-major order with w = w_base + j*ni + i.
    task automatic push_layer(input int ni, input int no, input int ib, input int ob, input int wb,
                              input int first_cyc, input int stall_after, input int stall_len,
                              input int max_beats);
        beat_t b;
        int k = 0;
        for (int j = 0; j < no; j++) begin
            for (int i = 0; i < ni; i++) begin
                if (k >= max_beats) return;
                b.in_addr = 12'(ib + i);
                b.w_addr  = 16'(wb + j * ni + i);
                b.tag     = 12'(ob + j);
                b.clr     = (i == 0);
                b.wr      = (i == ni - 1);
                b.dn      = (i == ni - 1) && (j == no - 1);
                if (first_cyc < 0) b.cyc = -1;
                else b.cyc = first_cyc + k + ((stall_after > 0 && k >= stall_after) ? stall_len : 0);
                exp_q.push_back(b);
                k++;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge where the first beat is visible.
    task automatic start_layer(input int ni, input int no, input int ib, input int ob, input int wb,
                               input bit timed, input int stall_after, input int stall_len,
                               input int max_beats, output int load_cyc);
        bus.run         = 1'b1;
        bus.stall       = 1'b0;
        bus.num_inputs  = 12'(ni);
        bus.num_outputs = 12'(no);
        bus.in_base     = 12'(ib);
        bus.out_base    = 12'(ob);
        bus.w_base      = 16'(wb);
        bus.start       = 1'b1;
        load_cyc = cyc + 1;
        push_layer(ni, no, ib, ob, wb, timed ? load_cyc : -1, stall_after, stall_len, max_beats);
        @(negedge clk);
        bus.start       = 1'b0;
        bus.num_inputs  = 12'($urandom);
        bus.num_outputs = 12'($urandom);
        bus.in_base     = 12'($urandom);
        bus.out_base    = 12'($urandom);
        bus.w_base      = 16'($urandom);
    endtask

    task automatic check_drain(input int last_cyc);
        while (cyc < last_cyc) @(negedge clk);
        for (int k = 0; k < PD; k++) begin
            @(negedge clk);
            chk("drain_busy", bus.busy, 1);
            chk("drain_strobes", {bus.mac_valid, bus.mac_clear, bus.write_neuron_0, bus.done_0}, 0);
        end
        @(negedge clk);
        chk("busy_after_drain", bus.busy, 0);
        chk("beats_outstanding", exp_q.size(), 0);
    endtask

    // Random stall and ignored start pulses while busy, until the layer has drained.
    task automatic run_until_idle(input bit rnd, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            if (rnd) begin
                bus.stall       = ($urandom_range(0, 2) == 0);
                bus.start       = bus.busy && ($urandom_range(0, 3) == 0);
                bus.num_inputs  = 12'($urandom_range(0, 4));
                bus.num_outputs = 12'($urandom_range(0, 4));
            end
            n++;
        end while ((bus.busy || exp_q.size() != 0) && n < budget);
        bus.stall = 1'b0;
        bus.start = 1'b0;
        chk("layer_within_budget", (n < budget), 1);
        chk("beats_outstanding", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        beat_t b;
        if (bus.mac_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: in_addr=0x%0h w_addr=0x%0h at cycle %0d, none expected",
                         bus.in_addr, bus.w_addr, cyc);
            end else begin
                b = exp_q.pop_front();
                chk("in_addr", bus.in_addr, b.in_addr);
                chk("w_addr", bus.w_addr, b.w_addr);
                chk("out_neuron_addr_0", bus.out_neuron_addr_0, b.tag);
                chk("mac_clear", bus.mac_clear, b.clr);
                chk("write_neuron_0", bus.write_neuron_0, b.wr);
                chk("done_0", bus.done_0, b.dn);
                chk("beat_busy", bus.busy, 1);
                if (b.cyc >= 0) chk("beat_cycle", cyc, b.cyc);
            end
        end else begin
            chk("idle_strobes", {bus.mac_clear, bus.write_neuron_0}, 0);
            if (!allow_lone_done) chk("idle_done", bus.done_0, 0);
        end
    end

    initial begin
        int L;
        int ni;
        int no;
        bus.run = 1'b0;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.num_inputs = '0;
        bus.num_outputs = '0;
        bus.in_base = '0;
        bus.out_base = '0;
        bus.w_base = '0;
        repeat (3) @(negedge clk);
        chk("rst_mac_valid", bus.mac_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_addr", bus.in_addr, 0);
        chk("rst_w_addr", bus.w_addr, 0);
        chk("rst_tag", bus.out_neuron_addr_0, 0);
        chk("rst_strobes", {bus.mac_clear, bus.write_neuron_0, bus.done_0}, 0);

        // Basic 3x2 layer, start on the first edge after reset release.
        rst_n = 1'b1;
        start_layer(3, 2, 'h010, 'h200, 'h1000, 1'b1, 0, 0, 1000, L);
        check_drain(L + 5);

        // Same layer with a two-cycle stall after beat 2.
        start_layer(3, 2, 'h010, 'h200, 'h1000, 1'b1, 2, 2, 1000, L);
        @(negedge clk);
        bus.stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stall_strobes", {bus.mac_valid, bus.mac_clear, bus.write_neuron_0, bus.done_0}, 0);
            chk("stall_in_addr", bus.in_addr, 'h011);
            chk("stall_w_addr", bus.w_addr, 'h1001);
            chk("stall_tag", bus.out_neuron_addr_0, 'h200);
            chk("stall_busy", bus.busy, 1);
        end
        bus.stall = 1'b0;
        check_drain(L + 7);

        // Single-input neurons across the 16-bit weight wrap.
        start_layer(1, 3, 'h010, 'h200, 'hFFFF, 1'b1, 0, 0, 1000, L);
        check_drain(L + 2);

        // Empty layer: lone done_0, no beats, never busy.
        bus.num_inputs  = 12'd3;
        bus.num_outputs = 12'd0;
        bus.start       = 1'b1;
        allow_lone_done = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("zero_done", bus.done_0, 1);
        chk("zero_valid", bus.mac_valid, 0);
        chk("zero_busy", bus.busy, 0);
        @(negedge clk);
        allow_lone_done = 1'b0;
        chk("zero_done_once", bus.done_0, 0);
        chk("zero_busy_after", bus.busy, 0);

        // Abort with run low during beat 4, then a fresh layer from the bases.
        start_layer(3, 2, 'h010, 'h200, 'h1000, 1'b1, 0, 0, 4, L);
        repeat (3) @(negedge clk);
        bus.run = 1'b0;
        @(negedge clk);
        chk("abort_strobes", {bus.mac_valid, bus.mac_clear, bus.write_neuron_0, bus.done_0}, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_outstanding", exp_q.size(), 0);
        start_layer(3, 2, 'h010, 'h200, 'h1000, 1'b1, 0, 0, 1000, L);
        check_drain(L + 5);

        // Asynchronous reset mid-layer, off the clock edge.
        start_layer(3, 2, 'h010, 'h200, 'h1000, 1'b1, 0, 0, 3, L);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mac_valid", bus.mac_valid, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_addrs", {bus.in_addr, bus.w_addr, bus.out_neuron_addr_0}, 0);
        chk("arst_strobes", {bus.mac_clear, bus.write_neuron_0, bus.done_0}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_outstanding", exp_q.size(), 0);

        // Randomized layers with random stall and ignored start pulses.
        for (int t = 0; t < 12; t++) begin
            ni = $urandom_range(1, 5);
            no = $urandom_range(1, 4);
            start_layer(ni, no, $urandom_range(0, 4095), $urandom_range(0, 4095),
                        $urandom_range(0, 65535), 1'b0, 0, 0, 1000, L);
            run_until_idle(1'b1, 500);
        end

        repeat (3) @(negedge clk);
        chk("final_outstanding", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
